comparator_bist: RTL and testbench

- Self-checking stimulus engine for the combinational magnitude comparator block; it sits on the other side of that block's A/B/G/L/E interface.
- On start it sweeps every operand pair (A,B) into the comparator and samples the comparator's G/L/E outputs after a settle window.
- It checks the sampled outputs against a built-in golden model, counts mismatches and captures the first failing pair.
- Used as on-chip BIST and as the reusable driver/checker for comparator benches.

---
 rtl/comparator_pkg.sv | 17 +
 rtl/comparator_golden.sv | 21 ++
 rtl/comparator_bist.sv | 156 +++++++++++++++
 tb/tb_comparator_bist.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// comparator_pkg
//   Shared definitions for the comparator BIST engine: sweep FSM state
//   encoding, default operand width and the resulting vector count.
package comparator_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int NUM_VECTORS = 2**(2*DEF_WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/comparator_golden.sv
// comparator_golden
//   Combinational reference comparator, unsigned.
//   i_a, i_b          : operands
//   o_exp_g/l/e       : expected A>B, A<B, A==B
module comparator_golden
  import comparator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_exp_g,
  output logic             o_exp_l,
  output logic             o_exp_e
);

  assign o_exp_g = (i_a >  i_b);
  assign o_exp_l = (i_a <  i_b);
  assign o_exp_e = (i_a == i_b);

endmodule

// File: rtl/comparator_bist.sv
// comparator_bist
//   Sweeps every (A,B) operand pair into an external magnitude comparator,
//   samples its G/L/E outputs after a settle window and checks them against
//   comparator_golden. Counts failing vectors (saturating) and captures the
//   first failing pair.
//   clk, rst            : clock, async active-high reset
//   start               : launch a sweep (honoured in IDLE/DONE only)
//   busy, done, pass    : sweep status; pass valid while done
//   dut_a, dut_b        : registered operands driven to the comparator
//   dut_g, dut_l, dut_e : comparator outputs under test
//   err_count           : failing vector count, saturates at all-ones
//   first_fail_*        : first failing pair of the current sweep
module comparator_bist
  import comparator_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic                 dut_g,
  input  logic                 dut_l,
  input  logic                 dut_e,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_fail_valid,
  output logic [WIDTH-1:0]     first_fail_a,
  output logic [WIDTH-1:0]     first_fail_b
);

  localparam int IDX_W = 2*WIDTH;
  localparam int SC_W  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES-1);

  state_t               r_state, w_next;
  logic [IDX_W-1:0]     r_idx;        // {A,B}, B in the low bits so it runs fastest
  logic [SC_W-1:0]      r_settle;
  logic [WIDTH-1:0]     r_dut_a, r_dut_b;
  logic [ERR_CNT_W-1:0] r_err;
  logic                 r_ffv, r_pass;
  logic [WIDTH-1:0]     r_ffa, r_ffb;

  logic w_exp_g, w_exp_l, w_exp_e;
  logic w_mismatch, w_last, w_busy, w_done;

  comparator_golden #(.WIDTH(WIDTH)) u_golden (
    .i_a     (r_dut_a),
    .i_b     (r_dut_b),
    .o_exp_g (w_exp_g),
    .o_exp_l (w_exp_l),
    .o_exp_e (w_exp_e)
  );

  // Any wrong bit (including illegal combinations) makes the vector fail once.
  assign w_mismatch = (dut_g != w_exp_g) | (dut_l != w_exp_l) | (dut_e != w_exp_e);
  assign w_last     = (r_idx == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = APPLY;
      end
      APPLY: begin
        w_busy = 1'b1;
        w_next = WAIT;
      end
      WAIT: begin
        w_busy = 1'b1;
        if (r_settle == '0) w_next = CHECK;
      end
      CHECK: begin
        w_busy = 1'b1;
        w_next = w_last ? DONE : APPLY;
      end
      DONE: begin
        w_done = 1'b1;
        if (start) w_next = APPLY;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_settle <= '0;
      r_dut_a  <= '0;
      r_dut_b  <= '0;
      r_err    <= '0;
      r_ffv    <= 1'b0;
      r_ffa    <= '0;
      r_ffb    <= '0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_idx  <= '0;
            r_err  <= '0;
            r_ffv  <= 1'b0;
            r_ffa  <= '0;
            r_ffb  <= '0;
            r_pass <= 1'b0;
          end
        end
        APPLY: begin
          r_dut_a  <= r_idx[IDX_W-1:WIDTH];
          r_dut_b  <= r_idx[WIDTH-1:0];
          r_settle <= SC_LOAD;
        end
        WAIT: begin
          if (r_settle != '0) r_settle <= r_settle - 1'b1;
        end
        CHECK: begin
          if (w_mismatch) begin
            if (r_err != '1) r_err <= r_err + 1'b1;
            if (!r_ffv) begin
              r_ffv <= 1'b1;
              r_ffa <= r_dut_a;
              r_ffb <= r_dut_b;
            end
          end
          // pass is registered on DONE entry, so fold in this last vector too
          if (w_last) r_pass <= (r_err == '0) && !w_mismatch;
          else        r_idx  <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy             = w_busy;
  assign done             = w_done;
  assign pass             = r_pass;
  assign dut_a            = r_dut_a;
  assign dut_b            = r_dut_b;
  assign err_count        = r_err;
  assign first_fail_valid = r_ffv;
  assign first_fail_a     = r_ffa;
  assign first_fail_b     = r_ffb;

endmodule

// File: tb/tb_comparator_bist.sv
module tb_comparator_bist;
  localparam int W     = 4;
  localparam int SC    = 1;
  localparam int EW    = 9;
  localparam int NV    = 1 << (2*W);
  localparam int SWEEP = (2+SC)*NV;
  localparam int ESAT  = (1 << EW) - 1;

  logic          clk, rst, start;
  logic          busy, done, pass;
  logic [W-1:0]  dut_a, dut_b;
  logic          dut_g, dut_l, dut_e;
  logic [EW-1:0] err_count;
  logic          first_fail_valid;
  logic [W-1:0]  first_fail_a, first_fail_b;

  int mode;
  int cyc;
  int checks;
  int errors;

  typedef struct {
    int done_cyc;
    int err;
    bit ffv;
    int ffa;
    int ffb;
    bit pass;
  } exp_t;

  exp_t q[$];

  comparator_bist #(.WIDTH(W), .SETTLE_CYCLES(SC), .ERR_CNT_W(EW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .dut_a            (dut_a),
    .dut_b            (dut_b),
    .dut_g            (dut_g),
    .dut_l            (dut_l),
    .dut_e            (dut_e),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_a     (first_fail_a),
    .first_fail_b     (first_fail_b)
  );

  // Comparator attached to the engine; mode 0 is correct, others are faulty.
  function automatic logic [2:0] cmp_model(int m, int a, int b);
    logic g, l, e;
    g = (a > b);
    l = (a < b);
    e = (a == b);
    case (m)
      1: g = 1'b0;
      2: begin g = (a < b); l = (a > b); end
      3: e = !e;
      4: e = 1'b1;
      default: ;
    endcase
    return {g, l, e};
  endfunction

  assign {dut_g, dut_l, dut_e} = cmp_model(mode, int'(dut_a), int'(dut_b));

  function automatic exp_t predict(int m, int c0);
    exp_t e;
    e.done_cyc = c0 + SWEEP;
    e.err = 0; e.ffv = 0; e.ffa = 0; e.ffb = 0;
    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++)
        if (cmp_model(m, a, b) != cmp_model(0, a, b)) begin
          if (e.err < ESAT) e.err++;
          if (!e.ffv) begin e.ffv = 1; e.ffa = a; e.ffb = b; end
        end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: pops one expectation per rising done.
  initial begin
    int   busy_cnt;
    bit   done_q;
    exp_t e;
    busy_cnt = 0;
    done_q   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
        done_q   = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done && !done_q) begin
          if (q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            e = q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("busy_cycles", busy_cnt, SWEEP);
            check("err_count", int'(err_count), e.err);
            check("pass", int'(pass), int'(e.pass));
            check("ff_valid", int'(first_fail_valid), int'(e.ffv));
            check("ff_a", int'(first_fail_a), e.ffa);
            check("ff_b", int'(first_fail_b), e.ffb);
            check("hold_a", int'(dut_a), (1 << W) - 1);
            check("hold_b", int'(dut_b), (1 << W) - 1);
          end
          busy_cnt = 0;
        end
        done_q = done;
      end
    end
  end

  task automatic do_start(output int c0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while (!done && n < 3*SWEEP) begin
      @(negedge clk);
      n++;
    end
    if (!done) check({"timeout_", name}, 0, 1);
  endtask

  task automatic sweep(int m);
    int c0;
    mode = m;
    do_start(c0);
    q.push_back(predict(m, c0));
    wait_done("sweep");
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_count), 0);
    check({tag, "_ffv"}, int'(first_fail_valid), 0);
    check({tag, "_ffa"}, int'(first_fail_a), 0);
    check({tag, "_ffb"}, int'(first_fail_b), 0);
    check({tag, "_a"}, int'(dut_a), 0);
    check({tag, "_b"}, int'(dut_b), 0);
  endtask

  initial begin
    int c0, n, m;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean sweep; done/pass persist in DONE.
    sweep(0);
    repeat (4) @(negedge clk);
    check("done_hold", int'(done), 1);
    check("pass_hold", int'(pass), 1);

    // Faulty comparators: g stuck 0, g/l swapped, e inverted.
    sweep(1);
    sweep(2);
    sweep(3);

    // start pulse during a sweep is ignored; done time is unchanged.
    mode = 0;
    do_start(c0);
    q.push_back(predict(0, c0));
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_ignored_start", int'(busy), 1);
    wait_done("ignored_start");

    // Async reset mid-sweep at vector (6,4).
    mode = 2;
    do_start(c0);
    q.push_back(predict(2, c0));
    n = 0;
    while (!(dut_a == 4'd6 && dut_b == 4'd4) && n < 2*SWEEP) begin
      @(negedge clk);
      n++;
    end
    check("reach_6_4", int'(dut_a == 4'd6 && dut_b == 4'd4), 1);
    #2 rst = 1'b1;
    q.delete();
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    sweep(0);

    // start held high across DONE gives back-to-back sweeps.
    m = $urandom_range(1, 4);
    mode = m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    q.push_back(predict(m, c0));
    q.push_back(predict(m, c0 + SWEEP + 1));
    wait_done("b2b_first");
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_done_low", int'(done), 0);
    check("b2b_busy", int'(busy), 1);
    wait_done("b2b_second");

    // Random modes with random idle gaps.
    repeat (3) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      sweep($urandom_range(0, 4));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
